// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: reset constants, NOP encoding and the
// fetch-entry layout that travels from instruction memory to decode.
package cpu_fetch_pkg;

  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_PC_W       = 32;

  // Default-width fetch entry; the top builds the same layout at ADDR_W.
  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Shift-style synchronous FIFO with a registered head entry. Flush beats
// push and pop; the caller guarantees a push never arrives when full.
module ifetch_fifo #(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0,
  localparam int              AW         = $clog2(DEPTH),
  localparam int              CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q [DEPTH-1];
  logic [WIDTH-1:0] cur    [DEPTH];
  logic [WIDTH-1:0] nxt    [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_pos;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0) && !flush;
  assign do_push = push && !flush && (do_pop || (count_q != CW'(DEPTH)));
  assign wr_pos  = do_pop ? (count_q - CW'(1)) : count_q;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no latch can be inferred.
  always_comb begin
    cur[0] = head_q;
    for (int i = 1; i < DEPTH; i++) cur[i] = tail_q[i-1];
    nxt = cur;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) nxt[i] = cur[i+1];
    end
    if (do_push) nxt[wr_pos[AW-1:0]] = din;
  end

  always_comb begin
    count_d = count_q;
    if (flush)                  count_d = '0;
    else if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= RESET_HEAD;
      count_q <= '0;
    end else begin
      head_q  <= nxt[0];
      count_q <= count_d;
    end
  end

  // NOTE: storage behind the head is deliberately not reset; count_q
  // decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) tail_q[i-1] <= nxt[i];
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/ifetch_pipe.sv
// Decoupled instruction-fetch front end: credit-limited sequential fetch
// from a 1-cycle ROM into a prefetch FIFO, with redirect and programming-mode flush.
module ifetch_pipe
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 14,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_mode,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credits_used;
  logic              issue;
  logic              flush;
  logic              resp_push;
  logic              pop;
  entry_t            resp_entry;
  entry_t            head_entry;
  logic              unused_bits;

  // An issued fetch reserves a FIFO slot, so its response always fits.
  assign credits_used = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign issue        = !reset && !prog_mode && !redirect_valid &&
                        (credits_used < (CW+1)'(DEPTH));
  assign flush        = prog_mode || redirect_valid;
  assign resp_push    = inflight_q && !flush;
  assign out_valid    = (fifo_count != '0) && !prog_mode;
  assign pop          = out_valid && out_ready;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      // Holding RESET_PC throughout programming mode restarts fetch there.
      if (prog_mode)           fetch_pc_q <= RESET_PC;
      else if (redirect_valid) fetch_pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (issue)          fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
    end
  end

  assign resp_entry = '{instr: imem_rdata, pc: inflight_pc_q};

  ifetch_fifo #(
    .WIDTH      ($bits(entry_t)),
    .DEPTH      (DEPTH),
    .RESET_HEAD ({ZERO_WORD, RESET_PC})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (resp_push),
    .pop   (pop),
    .flush (flush),
    .din   (resp_entry),
    .count (fifo_count),
    .head  (head_entry)
  );

  assign out_instr    = head_entry.instr;
  assign out_pc       = head_entry.pc;
  assign out_pc_plus4 = head_entry.pc + ADDR_W'(4);

  assign unused_bits = ^{redirect_pc[1:0], fetch_pc_q[1:0],
                         fetch_pc_q[ADDR_W-1:IMEM_AW+2]};

endmodule
